// File: rtl/instruction_fetch_unit.sv
// KGP-RISC fetch front end: holds the PC, fetches words over req/valid and issues them downstream.
// The optional taken-branch counter is built only when BRANCH_COUNT_EN is defined.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
`ifdef BRANCH_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_valid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ins_out,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [31:0]      pc_cur,
    output logic [31:0]      dest_addr,
    output logic [1:0]       branch_control_signal,
    output logic [5:0]       ins_func_code,
    input  logic [31:0]      pc_next
`ifdef BRANCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] branch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        ins_valid_q, ins_valid_d;
    logic [31:0] nxt_q, nxt_d;
    logic        accept;

    assign accept = (state_q == ISSUE) && ins_valid_q && ins_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ins_q       <= 32'd0;
            ins_valid_q <= 1'b0;
            nxt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            nxt_q       <= nxt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        nxt_d       = nxt_q;
        imem_req    = 1'b0;
        case (state_q)
            FETCH: begin
                // Request is masked while reset is asserted so nothing leaks out mid-reset.
                imem_req = rst;
                if (imem_valid) begin
                    ins_d       = imem_rdata;
                    ins_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    nxt_d       = pc_next;
                    ins_valid_d = 1'b0;
                    state_d     = COMMIT;
                end
            end
            COMMIT: begin
                pc_d    = nxt_q;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

`ifdef BRANCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // A branch counts as taken whenever the returned PC is not the fall-through.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (pc_next != pc_q + 32'd1) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    assign branch_count = cnt_q;
`endif

    assign imem_addr     = pc_q;
    assign pc_cur        = pc_q;
    assign ins_out       = ins_q;
    assign ins_valid     = ins_valid_q;
    assign ins_func_code = ins_q[28:23];
    assign dest_addr     = pc_q + {{9{ins_q[22]}}, ins_q[22:0]};

    always_comb begin
        case (ins_q[31:29])
            3'b100:  branch_control_signal = 2'b00;
            3'b101:  branch_control_signal = 2'b01;
            3'b110:  branch_control_signal = 2'b10;
            default: branch_control_signal = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetch addresses and decodes are queued
// when stimulus is driven and compared when the DUT presents them.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] pc_cur;
    logic [31:0] dest_addr;
    logic [1:0]  branch_control_signal;
    logic [5:0]  ins_func_code;
    logic [31:0] pc_next;
`ifdef BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    instruction_fetch_unit #(.RESET_PC(32'd0)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_req              (imem_req),
        .imem_addr             (imem_addr),
        .imem_valid            (imem_valid),
        .imem_rdata            (imem_rdata),
        .ins_out               (ins_out),
        .ins_valid             (ins_valid),
        .ins_ready             (ins_ready),
        .pc_cur                (pc_cur),
        .dest_addr             (dest_addr),
        .branch_control_signal (branch_control_signal),
        .ins_func_code         (ins_func_code),
        .pc_next               (pc_next)
`ifdef BRANCH_COUNT_EN
        ,
        .branch_count          (branch_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [1:0]  ctrl;
        logic [5:0]  func;
        logic [31:0] dest;
    } dec_t;

    logic [31:0] addr_q[$];
    dec_t        dec_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_req = 0;
    logic [31:0] pc_model = 32'd0;
    logic [15:0] cnt_model = 16'd0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (imem_req === 1'b1);
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_fetch_addr();
        if (addr_q.size() == 0) check("addr_queue_empty", 32'd0, 32'd1);
        else check("imem_addr", imem_addr, addr_q.pop_front());
    endtask

    task automatic do_instr(input logic [31:0] ins, input logic [31:0] pcn, input int dly,
                            input logic [1:0] ectrl, input logic [31:0] edest, input bit chk_cad);
        bit   ok;
        dec_t e;
        wait_req(ok);
        if (!ok) return;
        check_fetch_addr();
        if (chk_cad) check("cadence", cyc - last_req, 32'd3);
        last_req = cyc;
        imem_valid = 1'b1;
        imem_rdata = ins;
        dec_q.push_back('{ins, ectrl, ins[28:23], edest});
        tick();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        check("ins_valid_issue", {31'd0, ins_valid}, 32'd1);
        check("req_issue", {31'd0, imem_req}, 32'd0);
        e = dec_q.pop_front();
        check("ins_out", ins_out, e.ins);
        check("ctrl", {30'd0, branch_control_signal}, {30'd0, e.ctrl});
        check("func", {26'd0, ins_func_code}, {26'd0, e.func});
        check("dest_addr", dest_addr, e.dest);
        for (int i = 0; i < dly; i++) begin
            imem_valid = 1'b1;
            imem_rdata = ~ins;
            tick();
            imem_valid = 1'b0;
            check("ins_out_hold", ins_out, e.ins);
            check("ins_valid_hold", {31'd0, ins_valid}, 32'd1);
            check("req_hold", {31'd0, imem_req}, 32'd0);
        end
        ins_ready = 1'b1;
        pc_next = pcn;
        addr_q.push_back(pcn);
        if (pcn != pc_model + 32'd1 && cnt_model != 16'hFFFF) cnt_model++;
        pc_model = pcn;
        tick();
        pc_next = $urandom;
        check("ins_valid_commit", {31'd0, ins_valid}, 32'd0);
        check("req_commit", {31'd0, imem_req}, 32'd0);
`ifdef BRANCH_COUNT_EN
        check("branch_count", {16'd0, branch_count}, {16'd0, cnt_model});
`endif
        tick();
        ins_ready = 1'b0;
    endtask

    initial begin : stim
        bit ok;
        rst = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'd0;
        ins_ready = 1'b0;
        pc_next = 32'd0;
        repeat (2) begin
            tick();
            check("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
            check("rst_req", {31'd0, imem_req}, 32'd0);
        end
        rst = 1'b1;
        addr_q.push_back(32'd0);
        #1;
        check("req_after_rst", {31'd0, imem_req}, 32'd1);

        // pc 0 -> 5, then ADD at 5 -> 6 with back-to-back cadence
        do_instr({3'b000, 6'd0, 23'd0}, 32'd5, 0, 2'b11, 32'd0, 1'b0);
        do_instr({3'b000, 6'd1, 23'd7}, 32'd6, 0, 2'b11, 32'd12, 1'b0);
        do_instr({3'b000, 6'd0, 23'd0}, 32'd10, 0, 2'b11, 32'd6, 1'b1);
        // b at 10, offset -4
        do_instr({3'b101, 6'd0, 23'h7FFFFC}, 32'd6, 0, 2'b01, 32'd6, 1'b0);
        do_instr({3'b000, 6'd0, 23'd0}, 32'd20, 0, 2'b11, 32'd6, 1'b1);
        // bz not taken at 20 with a stalled consumer
        do_instr({3'b100, 6'd2, 23'd3}, 32'd21, 4, 2'b00, 32'd23, 1'b0);
        do_instr({3'b110, 6'h3F, 23'h400000}, 32'hFFFFFFFF, 0, 2'b10, 32'hFFC00015, 1'b0);
        // wrap at the top of the address space
        do_instr({3'b000, 6'd0, 23'd1}, 32'd0, 0, 2'b11, 32'd0, 1'b0);
        do_instr({3'b111, 6'd5, 23'd2}, 32'd1, 1, 2'b11, 32'd2, 1'b0);

        // reset while an instruction sits in ISSUE, with a stray imem_valid
        wait_req(ok);
        if (ok) begin
            check_fetch_addr();
            imem_valid = 1'b1;
            imem_rdata = 32'hA5A5A5A5;
            tick();
            check("ins_valid_pre_rst", {31'd0, ins_valid}, 32'd1);
            rst = 1'b0;
            imem_rdata = 32'h5A5A5A5A;
            tick();
            check("ins_valid_in_rst", {31'd0, ins_valid}, 32'd0);
            check("ins_out_in_rst", ins_out, 32'd0);
            check("req_in_rst", {31'd0, imem_req}, 32'd0);
            tick();
            check("ins_valid_late_valid", {31'd0, ins_valid}, 32'd0);
            imem_valid = 1'b0;
            rst = 1'b1;
            addr_q.delete();
            addr_q.push_back(32'd0);
            pc_model = 32'd0;
            cnt_model = 16'd0;
            #1;
            check("req_after_rst2", {31'd0, imem_req}, 32'd1);
            check("ins_valid_after_rst2", {31'd0, ins_valid}, 32'd0);
        end
        do_instr({3'b101, 6'd9, 23'd4}, 32'd3, 0, 2'b01, 32'd4, 1'b0);
        wait_req(ok);
        if (ok) check_fetch_addr();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
